// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, PC step, default reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_STEP              = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   // beq offset: sign-extended word offset turned into a byte offset
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/fetch-address bundle between the control unit and the PC fetch stage.
// Latency: n/a (wires only).
// Backpressure: Stall from the datapath freezes the fetch stage; TakenCount exists only with REDIRECT_COUNT_EN.
interface pc_fetch_unit_if;

   logic        Stall;
   logic        Halt;
   logic        Branch;
   logic        Zero;
   logic        Jump;
   logic [15:0] Imm16;
   logic [25:0] JTarget;
   logic [31:0] Pc;
   logic [31:0] PcPlus4;
   logic        FetchValid;
   logic        Halted;
`ifdef REDIRECT_COUNT_EN
   logic [31:0] TakenCount;
`endif

   modport master (
      output Stall, Halt, Branch, Zero, Jump, Imm16, JTarget,
      input  Pc, PcPlus4, FetchValid, Halted
`ifdef REDIRECT_COUNT_EN
      , input TakenCount
`endif
   );

   modport slave (
      input  Stall, Halt, Branch, Zero, Jump, Imm16, JTarget,
      output Pc, PcPlus4, FetchValid, Halted
`ifdef REDIRECT_COUNT_EN
      , output TakenCount
`endif
   );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection: jump over taken branch over sequential, with a taken flag.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is committed.
module pc_next_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic [25:0] jtarget,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] pc_next,
   output logic [31:0] pc_plus4,
   output logic        taken
);

   logic [31:0] jump_pc;
   logic [31:0] branch_pc;

   assign pc_plus4  = pc + PC_STEP;
   // jump keeps the region bits of the sequential PC, not of the current PC
   assign jump_pc   = {pc_plus4[31:28], jtarget, 2'b00};
   assign branch_pc = pc_plus4 + branch_offset(imm16);

   always_comb begin
      pc_next = pc_plus4;
      taken   = 1'b0;
      if (jump) begin
         pc_next = jump_pc;
         taken   = 1'b1;
      end else if (branch && zero) begin
         pc_next = branch_pc;
         taken   = 1'b1;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and BOOT/RUN/HALT fetch sequencer in front of instruction memory (REDIRECT_COUNT_EN adds TakenCount).
// Latency: a redirect presented in cycle n is on Pc in cycle n+1; no delay slots.
// Backpressure: Stall holds Pc and state; HALT is sticky until Rst.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          ADDR_W       = 32
) (
   input  logic          Clk,
   input  logic          Rst,
   pc_fetch_unit_if.slave fe
);

   localparam logic [ADDR_W-1:0] RV = {RESET_VECTOR[ADDR_W-1:2], 2'b00};

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc_q;
   logic              fetch_valid_q;
   logic              halted_q;

   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pc_plus4;
   logic              taken;

   pc_next_calc u_next (
      .pc       (pc_q),
      .imm16    (fe.Imm16),
      .jtarget  (fe.JTarget),
      .jump     (fe.Jump),
      .branch   (fe.Branch),
      .zero     (fe.Zero),
      .pc_next  (pc_next),
      .pc_plus4 (pc_plus4),
      .taken    (taken)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state         <= ST_BOOT;
         pc_q          <= RV;
         fetch_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state         <= ST_RUN;
               fetch_valid_q <= 1'b1;
            end
            ST_RUN: begin
               if (!fe.Stall) begin
                  if (fe.Halt) begin
                     state         <= ST_HALT;
                     fetch_valid_q <= 1'b0;
                     halted_q      <= 1'b1;
                  end else begin
                     pc_q <= pc_next;
                  end
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               // unreachable encoding: stop fetching rather than run from a bad PC
               state         <= ST_HALT;
               fetch_valid_q <= 1'b0;
               halted_q      <= 1'b1;
            end
         endcase
      end
   end

   assign fe.Pc         = pc_q;
   assign fe.PcPlus4    = pc_plus4;
   assign fe.FetchValid = fetch_valid_q;
   assign fe.Halted     = halted_q;

`ifdef REDIRECT_COUNT_EN
   logic [31:0] taken_cnt_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         taken_cnt_q <= 32'd0;
      end else if (state == ST_RUN && !fe.Stall && !fe.Halt && taken &&
                   taken_cnt_q != 32'hFFFF_FFFF) begin
         taken_cnt_q <= taken_cnt_q + 32'd1;
      end
   end

   assign fe.TakenCount = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and random checks of two pc_fetch_unit instances (reset vectors 0 and 0x4000_0000) against a reference model.
module tb_pc_fetch_unit;
   import mips_pkg::*;

   localparam logic [31:0] RV_A = 32'h0000_0000;
   localparam logic [31:0] RV_B = 32'h4000_0000;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   pc_fetch_unit_if ifa ();
   pc_fetch_unit_if ifb ();

   pc_fetch_unit #(.RESET_VECTOR(RV_A), .ADDR_W(32)) dut_a (.Clk(Clk), .Rst(Rst), .fe(ifa.slave));
   pc_fetch_unit #(.RESET_VECTOR(RV_B), .ADDR_W(32)) dut_b (.Clk(Clk), .Rst(Rst), .fe(ifb.slave));

   int nvec = 0;
   int nerr = 0;

   logic [31:0] m_rv   [2];
   logic [31:0] m_pc   [2];
   bit          m_run  [2];
   bit          m_halt [2];
   logic [31:0] m_cnt  [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit st, input bit h, input bit br, input bit z, input bit j,
                        input logic [15:0] imm, input logic [25:0] jt);
      ifa.Stall = st; ifa.Halt = h; ifa.Branch = br; ifa.Zero = z; ifa.Jump = j;
      ifa.Imm16 = imm; ifa.JTarget = jt;
      ifb.Stall = st; ifb.Halt = h; ifb.Branch = br; ifb.Zero = z; ifb.Jump = j;
      ifb.Imm16 = imm; ifb.JTarget = jt;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pc[i]   = m_rv[i] & 32'hFFFF_FFFC;
         m_run[i]  = 1'b0;
         m_halt[i] = 1'b0;
         m_cnt[i]  = 32'd0;
      end
   endtask

   task automatic model_edge(input bit st, input bit h, input bit br, input bit z, input bit j,
                             input logic [15:0] imm, input logic [25:0] jt);
      logic [31:0] p4;
      logic [31:0] off;
      bit          redirect;
      for (int i = 0; i < 2; i++) begin
         if (m_halt[i]) continue;
         if (!m_run[i]) begin
            m_run[i] = 1'b1;
            continue;
         end
         if (st) continue;
         if (h) begin
            m_halt[i] = 1'b1;
            continue;
         end
         p4 = m_pc[i] + 32'd4;
         redirect = 1'b0;
         if (j) begin
            m_pc[i] = (p4 & 32'hF000_0000) | (32'(jt) * 32'd4);
            redirect = 1'b1;
         end else if (br && z) begin
            off = imm[15] ? (32'(imm) - 32'h0001_0000) : 32'(imm);
            m_pc[i] = p4 + off * 32'd4;
            redirect = 1'b1;
         end else begin
            m_pc[i] = p4;
         end
         if (redirect && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] pc, p4, fv, hl;
      for (int i = 0; i < 2; i++) begin
         pc = (i == 0) ? ifa.Pc         : ifb.Pc;
         p4 = (i == 0) ? ifa.PcPlus4    : ifb.PcPlus4;
         fv = (i == 0) ? 32'(ifa.FetchValid) : 32'(ifb.FetchValid);
         hl = (i == 0) ? 32'(ifa.Halted)     : 32'(ifb.Halted);
         chk($sformatf("%s.%0d.pc", tag, i), pc, m_pc[i]);
         chk($sformatf("%s.%0d.pcplus4", tag, i), p4, m_pc[i] + 32'd4);
         chk($sformatf("%s.%0d.fetchvalid", tag, i), fv, 32'(m_run[i] && !m_halt[i]));
         chk($sformatf("%s.%0d.halted", tag, i), hl, 32'(m_halt[i]));
`ifdef REDIRECT_COUNT_EN
         chk($sformatf("%s.%0d.takencount", tag, i),
             (i == 0) ? ifa.TakenCount : ifb.TakenCount, m_cnt[i]);
`endif
      end
   endtask

   task automatic step(input string tag, input bit st, input bit h, input bit br, input bit z,
                       input bit j, input logic [15:0] imm, input logic [25:0] jt);
      drive(st, h, br, z, j, imm, jt);
      @(posedge Clk);
      model_edge(st, h, br, z, j, imm, jt);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 16'h0, 26'h0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check_all({tag, "_boot"});
   endtask

   initial begin
      m_rv[0] = RV_A;
      m_rv[1] = RV_B;
      drive(0, 0, 0, 0, 0, 16'h0, 26'h0);
      Rst = 1'b1;
      model_reset();
      #12;
      check_all("reset");
      chk("tp_reset_pc", ifa.Pc, 32'h0);
      chk("tp_reset_fv", 32'(ifa.FetchValid), 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check_all("boot");

      // BOOT -> RUN without a PC change, then sequential fetch
      idle("run_entry");
      chk("tp_run_pc", ifa.Pc, 32'h0);
      chk("tp_run_fv", 32'(ifa.FetchValid), 32'd1);
      idle("seq1"); chk("tp_seq1", ifa.Pc, 32'h4);
      idle("seq2"); chk("tp_seq2", ifa.Pc, 32'h8);
      idle("seq3"); chk("tp_seq3", ifa.Pc, 32'hC);
      idle("seq4"); chk("tp_seq4", ifa.Pc, 32'h10);

      step("br_taken", 0, 0, 1, 1, 0, 16'hFFFE, 26'h0);
      chk("tp_br_taken", ifa.Pc, 32'h0C);
      idle("seq5");
      step("br_not_taken", 0, 0, 1, 0, 0, 16'hFFFE, 26'h0);
      chk("tp_br_not_taken", ifa.Pc, 32'h14);

      // negative offset below zero, then sequential wrap back to zero
      step("jmp_zero", 0, 0, 0, 0, 1, 16'h0, 26'h0);
      chk("tp_jmp_zero", ifa.Pc, 32'h0);
      step("br_wrap", 0, 0, 1, 1, 0, 16'hFFFE, 26'h0);
      chk("tp_br_wrap", ifa.Pc, 32'hFFFF_FFFC);
      idle("seq_wrap");
      chk("tp_seq_wrap", ifa.Pc, 32'h0);

      for (int k = 0; k < 3; k++) begin
         step("stall", 1, 1, 1, 1, 1, 16'h0040, 26'h0000_123);
         chk("tp_stall_pc", ifa.Pc, 32'h0);
         chk("tp_stall_fv", 32'(ifa.FetchValid), 32'd1);
      end
      step("halt", 0, 1, 0, 0, 0, 16'h0, 26'h0);
      chk("tp_halted", 32'(ifa.Halted), 32'd1);
      chk("tp_halt_fv", 32'(ifa.FetchValid), 32'd0);
      step("halt_jmp", 0, 0, 0, 0, 1, 16'h0, 26'h0000_123);
      chk("tp_halt_frozen", ifa.Pc, 32'h0);

      // asynchronous reset in the middle of a cycle
      #2;
      Rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      chk("tp_async_b_pc", ifb.Pc, RV_B);
      chk("tp_async_halted", 32'(ifa.Halted), 32'd0);
      #2;
      Rst = 1'b0;

      idle("run_entry_b");
      chk("tp_b_run_pc", ifb.Pc, 32'h4000_0000);
      step("jmp_b", 0, 0, 0, 0, 1, 16'h0, 26'h0000_040);
      chk("tp_jmp_b", ifb.Pc, 32'h4000_0100);
      step("jmp_and_br", 0, 0, 1, 1, 1, 16'h0010, 26'h0000_080);
      chk("tp_jmp_wins", ifb.Pc, 32'h4000_0200);

`ifdef REDIRECT_COUNT_EN
      do_reset("cnt_rst");
      idle("cnt_run");
      step("cnt_br1", 0, 0, 1, 1, 0, 16'h0004, 26'h0);
      step("cnt_br2", 0, 0, 1, 1, 0, 16'h0004, 26'h0);
      step("cnt_jmp", 0, 0, 0, 0, 1, 16'h0, 26'h0000_010);
      step("cnt_nt",  0, 0, 1, 0, 0, 16'h0004, 26'h0);
      step("cnt_stall", 1, 0, 0, 0, 1, 16'h0, 26'h0000_200);
      chk("tp_taken_count", ifa.TakenCount, 32'd3);
`endif

      for (int blk = 0; blk < 6; blk++) begin
         do_reset("rnd_rst");
         idle("rnd_run");
         for (int k = 0; k < 60; k++) begin
            step("rnd",
                 ($urandom % 5) == 0,
                 ($urandom % 40) == 0,
                 1'($urandom),
                 1'($urandom),
                 ($urandom % 4) == 0,
                 16'($urandom),
                 26'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
